// File: rtl/arp_pkg.sv
// Shared ARP definitions: opcodes, broadcast address, local address defaults
// and the controller state encoding.
package arp_pkg;

  localparam logic        ARP_OP_REQ = 1'b1;
  localparam logic        ARP_OP_RSP = 1'b0;
  localparam logic [47:0] BCAST_MAC  = 48'hFF_FF_FF_FF_FF_FF;

  // Defaults shared with arp_rx / arp_tx so every block agrees on our address.
  localparam logic [47:0] DEF_FPGA_MAC = 48'h00_11_22_33_44_55;
  localparam logic [31:0] DEF_FPGA_IP  = 32'hc0_a8_00_03;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SEND_REQ    = 3'd1,
    ST_WAIT_TX_REQ = 3'd2,
    ST_WAIT_REPLY  = 3'd3,
    ST_SEND_RSP    = 3'd4,
    ST_WAIT_TX_RSP = 3'd5
  } arp_state_e;

endpackage

// File: rtl/arp_timeout_cnt.sv
// Reply timeout counter: cleared by load, counts while enabled, saturates at
// TIMEOUT_CYCLES-1 and flags expiry while enabled at that value.
module arp_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 125_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_cnt;

  // Saturating count so a stalled FSM can never see the timer wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/arp_ctrl.sv
// ARP transaction controller: answers incoming requests, resolves a target IP
// with timeout/retry and keeps a single-entry peer cache.
module arp_ctrl
  import arp_pkg::*;
#(
  parameter logic [47:0] FPGA_MAC       = DEF_FPGA_MAC,
  parameter logic [31:0] FPGA_IP        = DEF_FPGA_IP,
  parameter int unsigned TIMEOUT_CYCLES = 125_000_000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic        arp_clk,
  input  logic        rst,
  input  logic        arp_rx_done,
  input  logic        arp_rx_op,
  input  logic [47:0] rx_src_mac,
  input  logic [31:0] rx_src_ip,
  input  logic        arp_req_start,
  input  logic [31:0] arp_req_ip,
  output logic        arp_tx_start,
  output logic        arp_tx_op,
  output logic [47:0] arp_tx_dst_mac,
  output logic [31:0] arp_tx_dst_ip,
  input  logic        arp_tx_done,
  output logic        cache_valid,
  output logic [47:0] cache_mac,
  output logic [31:0] cache_ip,
  output logic        arp_ok,
  output logic        arp_fail,
  output logic        busy
);

  localparam logic [3:0] MAX_RETRY_C = 4'(MAX_RETRY);

  arp_state_e  r_state, w_next;
  logic        r_pend, r_tx_start, r_tx_op, r_cache_valid, r_ok, r_fail, r_busy;
  logic [47:0] r_rsp_mac, r_tx_dst_mac, r_cache_mac;
  logic [31:0] r_rsp_ip, r_tgt_ip, r_tx_dst_ip, r_cache_ip;
  logic [3:0]  r_retry;
  logic        w_rx_req, w_rx_match, w_tmr_load, w_tmr_en, w_expire;
  logic        w_go_rsp, w_go_req, w_send_req, w_send_rsp, w_hit, w_retry, w_fail;

  // Our addresses are inserted by arp_tx; they are kept here so the parameter set matches.
  logic w_unused_params;
  assign w_unused_params = ^{FPGA_MAC, FPGA_IP};

  assign w_rx_req   = arp_rx_done && (arp_rx_op == ARP_OP_REQ);
  assign w_rx_match = arp_rx_done && (arp_rx_op == ARP_OP_RSP) && (rx_src_ip == r_tgt_ip);
  assign w_tmr_load = (r_state == ST_WAIT_TX_REQ) && arp_tx_done;
  assign w_tmr_en   = (r_state == ST_WAIT_REPLY);

  arp_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmr (
    .i_clk    (arp_clk),
    .i_rst    (rst),
    .i_load   (w_tmr_load),
    .i_en     (w_tmr_en),
    .o_expire (w_expire)
  );

  // State register.
  always_ff @(posedge arp_clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and one-cycle action strobes.
  always_comb begin
    w_next     = r_state;
    w_go_rsp   = 1'b0;
    w_go_req   = 1'b0;
    w_send_req = 1'b0;
    w_send_rsp = 1'b0;
    w_hit      = 1'b0;
    w_retry    = 1'b0;
    w_fail     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A request seen this very cycle counts as pending and beats arp_req_start.
        if (r_pend || w_rx_req) begin
          w_next   = ST_SEND_RSP;
          w_go_rsp = 1'b1;
        end else if (arp_req_start) begin
          w_next   = ST_SEND_REQ;
          w_go_req = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_SEND_REQ: begin
        w_next     = ST_WAIT_TX_REQ;
        w_send_req = 1'b1;
      end
      ST_WAIT_TX_REQ: begin
        if (arp_tx_done) begin
          w_next = ST_WAIT_REPLY;
        end else begin
          w_next = ST_WAIT_TX_REQ;
        end
      end
      ST_WAIT_REPLY: begin
        if (w_rx_match) begin
          w_next = ST_IDLE;
          w_hit  = 1'b1;
        end else if (w_expire) begin
          if (r_retry < MAX_RETRY_C) begin
            w_next  = ST_SEND_REQ;
            w_retry = 1'b1;
          end else begin
            w_next = ST_IDLE;
            w_fail = 1'b1;
          end
        end else begin
          w_next = ST_WAIT_REPLY;
        end
      end
      ST_SEND_RSP: begin
        w_next     = ST_WAIT_TX_RSP;
        w_send_rsp = 1'b1;
      end
      ST_WAIT_TX_RSP: begin
        if (arp_tx_done) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_WAIT_TX_RSP;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge arp_clk or posedge rst) begin
    if (rst) begin
      r_pend        <= 1'b0;
      r_rsp_mac     <= 48'h0;
      r_rsp_ip      <= 32'h0;
      r_tgt_ip      <= 32'h0;
      r_retry       <= 4'd0;
      r_tx_start    <= 1'b0;
      r_tx_op       <= 1'b0;
      r_tx_dst_mac  <= 48'h0;
      r_tx_dst_ip   <= 32'h0;
      r_cache_valid <= 1'b0;
      r_cache_mac   <= 48'h0;
      r_cache_ip    <= 32'h0;
      r_ok          <= 1'b0;
      r_fail        <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      if (w_go_rsp) begin
        r_pend <= 1'b0;
      end else if (w_rx_req) begin
        r_pend <= 1'b1;
      end
      // Latest requester wins; the frame being sent already holds its own copy.
      if (w_rx_req) begin
        r_rsp_mac <= rx_src_mac;
        r_rsp_ip  <= rx_src_ip;
      end
      if (w_go_req) begin
        r_tgt_ip <= arp_req_ip;
        r_retry  <= 4'd0;
      end else if (w_retry) begin
        r_retry <= r_retry + 4'd1;
      end
      r_tx_start <= w_send_req || w_send_rsp;
      if (w_send_req) begin
        r_tx_op      <= ARP_OP_REQ;
        r_tx_dst_mac <= BCAST_MAC;
        r_tx_dst_ip  <= r_tgt_ip;
      end else if (w_send_rsp) begin
        r_tx_op      <= ARP_OP_RSP;
        r_tx_dst_mac <= r_rsp_mac;
        r_tx_dst_ip  <= r_rsp_ip;
      end
      if (w_go_req) begin
        r_cache_valid <= 1'b0;
      end else if (w_hit) begin
        r_cache_valid <= 1'b1;
        r_cache_mac   <= rx_src_mac;
        r_cache_ip    <= rx_src_ip;
      end
      r_ok   <= w_hit;
      r_fail <= w_fail;
      r_busy <= (w_next != ST_IDLE);
    end
  end

  assign arp_tx_start   = r_tx_start;
  assign arp_tx_op      = r_tx_op;
  assign arp_tx_dst_mac = r_tx_dst_mac;
  assign arp_tx_dst_ip  = r_tx_dst_ip;
  assign cache_valid    = r_cache_valid;
  assign cache_mac      = r_cache_mac;
  assign cache_ip       = r_cache_ip;
  assign arp_ok         = r_ok;
  assign arp_fail       = r_fail;
  assign busy           = r_busy;

endmodule

// File: tb/tb_arp_ctrl.sv
// Directed bench for arp_ctrl with TIMEOUT_CYCLES=100, MAX_RETRY=2.
module tb_arp_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arp_rx_done = 1'b0;
  logic        arp_rx_op = 1'b0;
  logic [47:0] rx_src_mac = 48'h0;
  logic [31:0] rx_src_ip = 32'h0;
  logic        arp_req_start = 1'b0;
  logic [31:0] arp_req_ip = 32'h0;
  logic        arp_tx_done = 1'b0;
  logic        arp_tx_start, arp_tx_op, cache_valid, arp_ok, arp_fail, busy;
  logic [47:0] arp_tx_dst_mac, cache_mac;
  logic [31:0] arp_tx_dst_ip, cache_ip;

  int n_cmp = 0;
  int n_err = 0;
  int n_start = 0;
  int n_ok = 0;
  int n_fail = 0;

  arp_ctrl #(
    .TIMEOUT_CYCLES (100),
    .MAX_RETRY      (2)
  ) dut (
    .arp_clk        (clk),
    .rst            (rst),
    .arp_rx_done    (arp_rx_done),
    .arp_rx_op      (arp_rx_op),
    .rx_src_mac     (rx_src_mac),
    .rx_src_ip      (rx_src_ip),
    .arp_req_start  (arp_req_start),
    .arp_req_ip     (arp_req_ip),
    .arp_tx_start   (arp_tx_start),
    .arp_tx_op      (arp_tx_op),
    .arp_tx_dst_mac (arp_tx_dst_mac),
    .arp_tx_dst_ip  (arp_tx_dst_ip),
    .arp_tx_done    (arp_tx_done),
    .cache_valid    (cache_valid),
    .cache_mac      (cache_mac),
    .cache_ip       (cache_ip),
    .arp_ok         (arp_ok),
    .arp_fail       (arp_fail),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the inactive edge.
  always @(negedge clk) begin
    if (arp_tx_start) n_start <= n_start + 1;
    if (arp_ok)       n_ok    <= n_ok + 1;
    if (arp_fail)     n_fail  <= n_fail + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rx_pulse(input logic op, input logic [47:0] mac, input logic [31:0] ip);
    arp_rx_done = 1'b1;
    arp_rx_op   = op;
    rx_src_mac  = mac;
    rx_src_ip   = ip;
    cyc(1);
    arp_rx_done = 1'b0;
  endtask

  task automatic req_pulse(input logic [31:0] ip);
    arp_req_start = 1'b1;
    arp_req_ip    = ip;
    cyc(1);
    arp_req_start = 1'b0;
  endtask

  task automatic done_pulse();
    arp_tx_done = 1'b1;
    cyc(1);
    arp_tx_done = 1'b0;
  endtask

  task automatic wait_start(input int max, output int n);
    n = 0;
    while (!arp_tx_start && n < max) begin
      cyc(1);
      n++;
    end
  endtask

  initial begin
    int n;
    int b_start, b_ok, b_fail;

    // Reset state
    cyc(3);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_outs", 64'({arp_tx_start, arp_tx_op, arp_ok, arp_fail, cache_valid}), 64'h0);
    chk("rst_dst", 64'(arp_tx_dst_mac) | 64'(arp_tx_dst_ip), 64'h0);
    chk("rst_cache", 64'(cache_mac) | 64'(cache_ip), 64'h0);
    rst = 1'b0;

    // 1: incoming request answered
    b_start = n_start;
    rx_pulse(1'b1, 48'h001122AABBCC, 32'hc0a80002);
    chk("s1_busy", 64'(busy), 64'h1);
    chk("s1_nostart", 64'(arp_tx_start), 64'h0);
    cyc(1);
    chk("s1_start", 64'(arp_tx_start), 64'h1);
    chk("s1_op", 64'(arp_tx_op), 64'h0);
    chk("s1_mac", 64'(arp_tx_dst_mac), 64'h001122AABBCC);
    chk("s1_ip", 64'(arp_tx_dst_ip), 64'hc0a80002);
    cyc(4);
    chk("s1_hold", 64'({arp_tx_start, arp_tx_op, arp_tx_dst_mac}), 64'h001122AABBCC);
    done_pulse();
    chk("s1_idle", 64'(busy), 64'h0);
    cyc(3);
    chk("s1_count", 64'(n_start - b_start), 64'h1);

    // 2: resolution succeeds
    req_pulse(32'hc0a80002);
    chk("s2_busy", 64'(busy), 64'h1);
    cyc(1);
    chk("s2_start", 64'(arp_tx_start), 64'h1);
    chk("s2_op", 64'(arp_tx_op), 64'h1);
    chk("s2_bcast", 64'(arp_tx_dst_mac), 64'hFFFFFFFFFFFF);
    chk("s2_ip", 64'(arp_tx_dst_ip), 64'hc0a80002);
    cyc(9);
    done_pulse();
    cyc(19);
    rx_pulse(1'b0, 48'h66778899AABB, 32'hc0a80002);
    chk("s2_ok", 64'(arp_ok), 64'h1);
    chk("s2_valid", 64'(cache_valid), 64'h1);
    chk("s2_cmac", 64'(cache_mac), 64'h66778899AABB);
    chk("s2_cip", 64'(cache_ip), 64'hc0a80002);
    chk("s2_idle", 64'(busy), 64'h0);
    cyc(1);
    chk("s2_okpulse", 64'(arp_ok), 64'h0);

    // 3: retries exhausted (first request + 2 retries, each 102 cycles apart)
    b_start = n_start;
    b_fail  = n_fail;
    req_pulse(32'hc0a80005);
    cyc(1);
    chk("s3_start0", 64'(arp_tx_start), 64'h1);
    chk("s3_valid_clr", 64'(cache_valid), 64'h0);
    done_pulse();
    wait_start(300, n);
    chk("s3_gap1", 64'(n), 64'd101);
    chk("s3_rip", 64'({arp_tx_op, arp_tx_dst_ip}), 64'h1c0a80005);
    done_pulse();
    wait_start(300, n);
    chk("s3_gap2", 64'(n), 64'd101);
    done_pulse();
    cyc(99);
    chk("s3_nofail_yet", 64'(arp_fail), 64'h0);
    cyc(1);
    chk("s3_fail", 64'(arp_fail), 64'h1);
    chk("s3_idle", 64'(busy), 64'h0);
    chk("s3_valid", 64'(cache_valid), 64'h0);
    cyc(5);
    chk("s3_nstart", 64'(n_start - b_start), 64'd3);
    chk("s3_nfail", 64'(n_fail - b_fail), 64'd1);

    // 4: wrong sender ignored, retry on schedule, later match
    req_pulse(32'hc0a80002);
    cyc(1);
    done_pulse();
    cyc(29);
    rx_pulse(1'b0, 48'h111111111111, 32'hc0a80009);
    chk("s4_ignored", 64'({arp_ok, busy, cache_valid}), 64'h2);
    wait_start(300, n);
    chk("s4_retry_gap", 64'(n), 64'd71);
    done_pulse();
    cyc(9);
    rx_pulse(1'b0, 48'h0A0B0C0D0E0F, 32'hc0a80002);
    chk("s4_ok", 64'(arp_ok), 64'h1);
    chk("s4_cmac", 64'(cache_mac), 64'h0A0B0C0D0E0F);

    // 5a: simultaneous user start and incoming request
    b_start = n_start;
    arp_req_start = 1'b1;
    arp_req_ip    = 32'hc0a80007;
    rx_pulse(1'b1, 48'h00AABBCCDDEE, 32'hc0a80010);
    arp_req_start = 1'b0;
    cyc(1);
    chk("s5a_start", 64'(arp_tx_start), 64'h1);
    chk("s5a_op", 64'(arp_tx_op), 64'h0);
    chk("s5a_mac", 64'(arp_tx_dst_mac), 64'h00AABBCCDDEE);
    done_pulse();
    cyc(5);
    chk("s5a_dropped", 64'({n_start - b_start, busy}), 64'h2);
    chk("s5a_cache_kept", 64'(cache_valid), 64'h1);

    // 5b: matching reply on the timeout cycle wins
    b_ok = n_ok;
    req_pulse(32'hc0a80002);
    cyc(1);
    b_start = n_start + 1;
    done_pulse();
    cyc(99);
    rx_pulse(1'b0, 48'h223344556677, 32'hc0a80002);
    chk("s5b_ok", 64'(arp_ok), 64'h1);
    chk("s5b_idle", 64'(busy), 64'h0);
    chk("s5b_cmac", 64'(cache_mac), 64'h223344556677);
    cyc(5);
    chk("s5b_noretry", 64'(n_start - b_start), 64'h0);
    chk("s5b_nok", 64'(n_ok - b_ok), 64'h1);

    // 6a: reset in WAIT_REPLY
    req_pulse(32'hc0a80003);
    cyc(1);
    done_pulse();
    cyc(10);
    rst = 1'b1;
    #1;
    chk("s6a_busy", 64'(busy), 64'h0);
    chk("s6a_tx", 64'({arp_tx_op, arp_tx_dst_ip}), 64'h0);
    chk("s6a_cache", 64'({cache_valid, cache_mac}), 64'h0);
    cyc(2);
    rst = 1'b0;
    b_start = n_start;
    b_fail  = n_fail;
    cyc(150);
    chk("s6a_quiet", 64'({n_start - b_start, n_fail - b_fail}), 64'h0);

    // 6b: two requests while busy -> one reply to the second requester
    b_start = n_start;
    req_pulse(32'hc0a80004);
    cyc(1);
    done_pulse();
    cyc(5);
    rx_pulse(1'b1, 48'h000000000001, 32'hc0a80021);
    cyc(3);
    rx_pulse(1'b1, 48'h000000000002, 32'hc0a80022);
    cyc(5);
    chk("s6b_waiting", 64'({n_start - b_start, busy}), 64'h3);
    rx_pulse(1'b0, 48'h0000000000AA, 32'hc0a80004);
    chk("s6b_ok", 64'(arp_ok), 64'h1);
    cyc(1);
    chk("s6b_nostart", 64'(arp_tx_start), 64'h0);
    cyc(1);
    chk("s6b_start", 64'(arp_tx_start), 64'h1);
    chk("s6b_op", 64'(arp_tx_op), 64'h0);
    chk("s6b_mac", 64'(arp_tx_dst_mac), 64'h000000000002);
    chk("s6b_ip", 64'(arp_tx_dst_ip), 64'hc0a80022);
    done_pulse();
    cyc(5);
    chk("s6b_single", 64'(n_start - b_start), 64'd2);
    chk("s6b_idle", 64'(busy), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
